// File: rtl/grid_pixel_renderer.sv
// Battleship board pixel renderer: tracks the grid cell under the scanned pixel, fetches its status
// and overlays fill, hit glyphs, grid lines and the mouse cursor. Optional macro: CURSOR_BLINK_EN.
module grid_pixel_renderer #(
    parameter int GRID_COLS   = 10,
    parameter int GRID_ROWS   = 10,
    parameter int CELL_W      = 64,
    parameter int CELL_H      = 48,
    parameter int LINE_W      = 2,
    parameter int CURSOR_HALF = 5,
    parameter int GLYPH_T     = 3
`ifdef CURSOR_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 30
`endif
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [9:0]  mouse_pos_x,
    input  logic [9:0]  mouse_pos_y,
    output logic [3:0]  cell_rd_x,
    output logic [3:0]  cell_rd_y,
    input  logic [2:0]  cell_status,
    output logic [11:0] color_out
);

    localparam int OXW    = $clog2(CELL_W);
    localparam int OYW    = $clog2(CELL_H);
    localparam int RING_R = ((CELL_W < CELL_H) ? CELL_W : CELL_H) - 2 * LINE_W;

    localparam logic [OXW-1:0] OFF_X_LAST = OXW'(CELL_W - 1);
    localparam logic [OYW-1:0] OFF_Y_LAST = OYW'(CELL_H - 1);
    localparam logic [OXW-1:0] LINE_X     = OXW'(LINE_W);
    localparam logic [OYW-1:0] LINE_Y     = OYW'(LINE_W);
    localparam logic [3:0]     COL_OUT    = 4'(GRID_COLS);
    localparam logic [3:0]     ROW_OUT    = 4'(GRID_ROWS);
    localparam logic [10:0]    HALF       = 11'(CURSOR_HALF);

    localparam logic [11:0] C_BLACK  = 12'h000;
    localparam logic [11:0] C_SHIP   = 12'h555;
    localparam logic [11:0] C_PHIT   = 12'hE91;
    localparam logic [11:0] C_GLYPH  = 12'hF0C;
    localparam logic [11:0] C_CURSOR = 12'hF00;
    localparam logic [11:0] C_LINE   = 12'h00F;

    // Stage 0/1: the tracker registers double as the stage-1 payload for the current pixel.
    logic [OXW-1:0] off_x_q, off_x_c;
    logic [OYW-1:0] off_y_q, off_y_c;
    logic [3:0]     col_q, col_c;
    logic [3:0]     row_q, row_c;
    logic           en1, cur1;

    logic [10:0] px_w, py_w, mx_w, my_w;
    logic        hit_c, blink_c;

    always_comb begin
        // NOTE: defaults first so every path assigns each output and no latch is inferred.
        off_x_c = off_x_q + OXW'(1);
        col_c   = col_q;
        off_y_c = off_y_q;
        row_c   = row_q;
        if (off_x_q == OFF_X_LAST) begin
            off_x_c = '0;
            if (col_q != COL_OUT) col_c = col_q + 4'd1;
        end
        if (pix_x == '0) begin
            off_x_c = '0;
            col_c   = '0;
            if (pix_y == '0) begin
                off_y_c = '0;
                row_c   = '0;
            end else if (off_y_q == OFF_Y_LAST) begin
                off_y_c = '0;
                if (row_q != ROW_OUT) row_c = row_q + 4'd1;
            end else begin
                off_y_c = off_y_q + OYW'(1);
            end
        end
    end

    // Eleven-bit compares keep the cursor window from wrapping at screen edges.
    assign px_w  = {1'b0, pix_x};
    assign py_w  = {1'b0, pix_y};
    assign mx_w  = {1'b0, mouse_pos_x};
    assign my_w  = {1'b0, mouse_pos_y};
    assign hit_c = (px_w + HALF >= mx_w) && (px_w <= mx_w + HALF) &&
                   (py_w + HALF >= my_w) && (py_w <= my_w + HALF) && blink_c;

`ifdef CURSOR_BLINK_EN
    localparam int FCW = $clog2(BLINK_FRAMES + 1);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(BLINK_FRAMES - 1);

    logic [FCW-1:0] frame_cnt, frame_cnt_c;
    logic           blink_q;

    always_comb begin
        frame_cnt_c = frame_cnt;
        blink_c     = blink_q;
        if (pix_x == '0 && pix_y == '0) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt_c = '0;
                blink_c     = ~blink_q;
            end else begin
                frame_cnt_c = frame_cnt + FCW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            frame_cnt <= '0;
            blink_q   <= 1'b1;
        end else begin
            frame_cnt <= frame_cnt_c;
            blink_q   <= blink_c;
        end
    end
`else
    assign blink_c = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            off_x_q   <= '0;
            off_y_q   <= '0;
            col_q     <= '0;
            row_q     <= '0;
            cell_rd_x <= '0;
            cell_rd_y <= '0;
            en1       <= 1'b0;
            cur1      <= 1'b0;
        end else begin
            off_x_q   <= off_x_c;
            off_y_q   <= off_y_c;
            col_q     <= col_c;
            row_q     <= row_c;
            cell_rd_x <= (col_c == COL_OUT) ? 4'd0 : col_c;
            cell_rd_y <= (row_c == ROW_OUT) ? 4'd0 : row_c;
            en1       <= enable;
            cur1      <= hit_c;
        end
    end

    // Stage 1 -> 2: geometry flags, resolved while the board RAM answers.
    logic line_c, out_c, cross_c, ring_c;
    int   ox, oy, d_cross, d_mirror, dx, dy, d_ring;

    always_comb begin
        ox       = int'(off_x_q);
        oy       = int'(off_y_q);
        d_cross  = ox * CELL_H - oy * CELL_W;
        d_mirror = (CELL_W - 1 - ox) * CELL_H - oy * CELL_W;
        if (d_cross < 0) d_cross = -d_cross;
        if (d_mirror < 0) d_mirror = -d_mirror;
        cross_c  = (d_cross <= GLYPH_T * CELL_W) || (d_mirror <= GLYPH_T * CELL_W);
        // Doubled coordinates put the ring centre on a half-pixel without fractions.
        dx       = 2 * ox - CELL_W + 1;
        dy       = 2 * oy - CELL_H + 1;
        d_ring   = dx * dx + dy * dy - RING_R * RING_R;
        if (d_ring < 0) d_ring = -d_ring;
        ring_c   = d_ring <= GLYPH_T * RING_R;
        line_c   = (off_x_q < LINE_X && col_q != '0 && col_q < COL_OUT) ||
                   (off_y_q < LINE_Y && row_q != '0 && row_q < ROW_OUT);
        out_c    = (col_q == COL_OUT) || (row_q == ROW_OUT);
    end

    logic en2, cur2, line2, out2, cross2, ring2;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            en2    <= 1'b0;
            cur2   <= 1'b0;
            line2  <= 1'b0;
            out2   <= 1'b0;
            cross2 <= 1'b0;
            ring2  <= 1'b0;
        end else begin
            en2    <= en1;
            cur2   <= cur1;
            line2  <= line_c;
            out2   <= out_c;
            cross2 <= cross_c;
            ring2  <= ring_c;
        end
    end

    // Stage 2 -> 3: cell_status is valid now; resolve the overlay priority.
    logic [11:0] base_c, pix_c;

    always_comb begin
        base_c = C_BLACK;
        case (cell_status)
            3'd1:    base_c = C_SHIP;
            3'd2:    base_c = C_PHIT;
            3'd3:    if (cross2) base_c = C_GLYPH;
            3'd4:    if (ring2) base_c = C_GLYPH;
            default: base_c = C_BLACK;
        endcase
        if (!en2)       pix_c = C_BLACK;
        else if (cur2)  pix_c = C_CURSOR;
        else if (line2) pix_c = C_LINE;
        else if (out2)  pix_c = C_BLACK;
        else            pix_c = base_c;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) color_out <= C_BLACK;
        else        color_out <= pix_c;
    end

endmodule

// File: tb/tb_grid_pixel_renderer.sv
// Directed bench for grid_pixel_renderer: a reference model pushes expected colours per pixel into a
// scoreboard queue; entries are popped three clocks later against color_out.
module tb_grid_pixel_renderer;

    localparam int GRID_COLS   = 10;
    localparam int GRID_ROWS   = 10;
    localparam int CELL_W      = 64;
    localparam int CELL_H      = 48;
    localparam int LINE_W      = 2;
    localparam int CURSOR_HALF = 5;
    localparam int GLYPH_T     = 3;
    localparam int LATENCY     = 3;

    typedef struct {
        bit          chk;
        logic [11:0] col;
        int          x;
        int          y;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        enable = 1'b0;
    logic [9:0]  pix_x = '0, pix_y = '0, mouse_pos_x = '0, mouse_pos_y = '0;
    logic [3:0]  cell_rd_x, cell_rd_y;
    logic [2:0]  cell_status = '0;
    logic [11:0] color_out;

    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         mouse_x = 700;
    int         mouse_y = 500;
    logic [2:0] board[GRID_ROWS][GRID_COLS];

    grid_pixel_renderer #(
        .GRID_COLS(GRID_COLS), .GRID_ROWS(GRID_ROWS), .CELL_W(CELL_W), .CELL_H(CELL_H),
        .LINE_W(LINE_W), .CURSOR_HALF(CURSOR_HALF), .GLYPH_T(GLYPH_T)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .enable(enable),
        .pix_x(pix_x), .pix_y(pix_y),
        .mouse_pos_x(mouse_pos_x), .mouse_pos_y(mouse_pos_y),
        .cell_rd_x(cell_rd_x), .cell_rd_y(cell_rd_y),
        .cell_status(cell_status), .color_out(color_out)
    );

    always #5 clk_in = ~clk_in;

    // Board RAM: one clock read latency.
    always @(posedge clk_in) begin
        if (int'(cell_rd_x) < GRID_COLS && int'(cell_rd_y) < GRID_ROWS)
            cell_status <= board[cell_rd_y][cell_rd_x];
        else
            cell_status <= 3'd0;
    end

    function automatic logic [11:0] model(input int x, input int y, input bit en);
        int col, row, ox, oy, d1, d2, dx, dy, dr, r;
        logic [2:0] st;
        if (!en) return 12'h000;
        if (x + CURSOR_HALF >= mouse_x && x <= mouse_x + CURSOR_HALF &&
            y + CURSOR_HALF >= mouse_y && y <= mouse_y + CURSOR_HALF) return 12'hF00;
        col = x / CELL_W;
        row = y / CELL_H;
        if (col > GRID_COLS) col = GRID_COLS;
        if (row > GRID_ROWS) row = GRID_ROWS;
        ox = x % CELL_W;
        oy = y % CELL_H;
        if ((ox < LINE_W && col > 0 && col < GRID_COLS) ||
            (oy < LINE_W && row > 0 && row < GRID_ROWS)) return 12'h00F;
        if (col >= GRID_COLS || row >= GRID_ROWS) return 12'h000;
        st = board[row][col];
        case (st)
            3'd1: return 12'h555;
            3'd2: return 12'hE91;
            3'd3: begin
                d1 = ox * CELL_H - oy * CELL_W;
                d2 = (CELL_W - 1 - ox) * CELL_H - oy * CELL_W;
                if (d1 < 0) d1 = -d1;
                if (d2 < 0) d2 = -d2;
                return (d1 <= GLYPH_T * CELL_W || d2 <= GLYPH_T * CELL_W) ? 12'hF0C : 12'h000;
            end
            3'd4: begin
                r  = ((CELL_W < CELL_H) ? CELL_W : CELL_H) - 2 * LINE_W;
                dx = 2 * ox - CELL_W + 1;
                dy = 2 * oy - CELL_H + 1;
                dr = dx * dx + dy * dy - r * r;
                if (dr < 0) dr = -dr;
                return (dr <= GLYPH_T * r) ? 12'hF0C : 12'h000;
            end
            default: return 12'h000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pops the pixel driven LATENCY steps ago, then drives and records the next one.
    task automatic step(input int x, input int y, input bit en, input bit chk);
        exp_t e;
        @(negedge clk_in);
        if (sb.size() == LATENCY) begin
            e = sb.pop_front();
            if (e.chk) check($sformatf("px(%0d,%0d)", e.x, e.y), color_out, e.col);
        end
        pix_x       = 10'(x);
        pix_y       = 10'(y);
        enable      = en;
        mouse_pos_x = 10'(mouse_x);
        mouse_pos_y = 10'(mouse_y);
        e.chk = chk;
        e.col = model(x, y, en);
        e.x   = x;
        e.y   = y;
        sb.push_back(e);
    endtask

    task automatic scan_line(input int y, input int x_last);
        for (int x = 0; x <= x_last; x++) step(x, y, 1'b1, 1'b1);
    endtask

    task automatic drain();
        repeat (LATENCY) step(1, 0, 1'b0, 1'b1);
    endtask

    task automatic fill_board(input logic [2:0] st);
        for (int r = 0; r < GRID_ROWS; r++)
            for (int c = 0; c < GRID_COLS; c++) board[r][c] = st;
    endtask

    initial begin
        fill_board(3'd0);
        #1 rst_in = 1'b1;
        #1;
        check("reset_color", color_out, 12'h000);
        check("reset_rd_x", {8'h00, cell_rd_x}, 12'h000);
        check("reset_rd_y", {8'h00, cell_rd_y}, 12'h000);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Ship board, cursor parked off-screen: fills, grid lines, outside region.
        fill_board(3'd1);
        for (int y = 0; y < 480; y++) begin
            if (y == 0 || y == 1 || y == 2 || y == 50 || y == 100 || y == 200)
                scan_line(y, 679);
            else
                scan_line(y, 69);
        end
        for (int y = 480; y < 482; y++) scan_line(y, 40);
        drain();

        // Reset pulse mid-line: output clears at once, next line renders from pix_x==0.
        scan_line(0, 300);
        #2 rst_in = 1'b1;
        #1;
        check("midline_reset_color", color_out, 12'h000);
        check("midline_reset_rd_x", {8'h00, cell_rd_x}, 12'h000);
        @(negedge clk_in);
        rst_in = 1'b0;
        sb.delete();
        for (int x = 301; x < 640; x++) step(x, 0, 1'b1, 1'b0);
        scan_line(1, 99);
        drain();

        // Single-pixel enable drop inside a ship cell.
        for (int x = 0; x <= 40; x++) step(x, 0, (x != 30), 1'b1);
        drain();

        // Cursor near the origin, plus the far right edge of a full line.
        mouse_x = 2;
        mouse_y = 2;
        for (int y = 0; y < 10; y++) scan_line(y, (y == 3) ? 1023 : 11);
        drain();
        mouse_x = 700;
        mouse_y = 500;

        // Glyph row: cross, ring, player hit and an unused status code.
        fill_board(3'd0);
        board[3][2] = 3'd3;
        board[3][4] = 3'd4;
        board[3][5] = 3'd2;
        board[3][6] = 3'd5;
        for (int y = 0; y < 144; y++) step(0, y, 1'b1, 1'b1);
        for (int y = 144; y < 172; y++) begin
            for (int x = 0; x <= 450; x++) begin
                step(x, y, 1'b1, 1'b1);
                if (x == 130 && y == 146) begin
                    @(posedge clk_in);
                    #1;
                    check("glyph_rd_x", {8'h00, cell_rd_x}, 12'h002);
                    check("glyph_rd_y", {8'h00, cell_rd_y}, 12'h003);
                end
            end
        end
        drain();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
